// File: rtl/dds_lut_pkg.sv
// Shared types and constants for the waveform LUT loader.
// State encodings, header/field widths and the word-width legality check.
package dds_lut_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT,
    S_DHI,
    S_DLO,
    S_WR
  } state_e;

  localparam int HDR_LOAD_BIT = 7;
  localparam int BYTE_W       = 8;
  localparam int ADDR_FIELD_W = 7;
  localparam int CNT_W        = 9;
  localparam int WW_MIN       = 9;
  localparam int WW_MAX       = 16;

  function automatic bit ww_legal(int ww);
    return (ww >= WW_MIN) && (ww <= WW_MAX);
  endfunction

endpackage

// File: rtl/stream_timeout.sv
// Idle watchdog for a byte stream: counts enabled cycles since the last clear.
// Expire fires on the enabled cycle that would make the count reach TIMEOUT.
module stream_timeout #(
  parameter int TIMEOUT = 1023,
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_en & (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/lut_load_ctrl.sv
// Host byte-stream loader for the waveform LUT with DDS read gating.
// Packets: header, count, then n MSB-first word pairs written with auto-increment.
module lut_load_ctrl
  import dds_lut_pkg::*;
#(
  parameter int WW           = 12,
  parameter int DEPTH        = 128,
  parameter int TIMEOUT      = 1023,
  parameter bit HOLD_ON_LOAD = 1'b1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              lut_we,
  output logic [AW-1:0]     lut_wa,
  output logic [WW-1:0]     lut_wd,
  input  logic              dds_re_req,
  input  logic [AW-1:0]     dds_ra,
  output logic              lut_re,
  output logic [AW-1:0]     lut_ra,
  output logic              busy,
  output logic              done,
  output logic              err
);

  if (!ww_legal(WW)) begin : g_bad_ww
    $error("lut_load_ctrl: WW must be 9..16");
  end

  localparam logic [BYTE_W-1:0] DEPTH_B = BYTE_W'(DEPTH);

  state_e           r_state;
  logic [AW-1:0]    r_addr;
  logic [CNT_W-1:0] r_cnt;
  logic [WW-1:0]    r_word;
  logic             r_err;

  logic w_xfer;
  logic w_live;
  logic w_addr_bad;
  logic w_expire;

  assign w_xfer     = in_valid & in_ready;
  assign w_live     = (r_state == S_CNT) | (r_state == S_DHI) |
                      (r_state == S_DLO);
  assign w_addr_bad = {1'b0, in_data[ADDR_FIELD_W-1:0]} >= DEPTH_B;

  stream_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_xfer | (r_state == S_IDLE)),
    .i_en     (w_live & ~w_xfer),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_word  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: if (w_xfer) begin
          if (!in_data[HDR_LOAD_BIT] || w_addr_bad) begin
            r_err <= 1'b1;
          end else begin
            r_addr  <= in_data[AW-1:0];
            r_state <= S_CNT;
          end
        end
        S_CNT: if (w_xfer) begin
          r_cnt   <= {1'b0, in_data} + 1'b1;
          r_state <= S_DHI;
        end
        S_DHI: if (w_xfer) begin
          r_word[WW-1:8] <= in_data[WW-9:0];
          r_state        <= S_DLO;
        end
        S_DLO: if (w_xfer) begin
          r_word[7:0] <= in_data;
          r_state     <= S_WR;
        end
        S_WR: begin
          r_addr  <= (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + 1'b1;
          r_cnt   <= r_cnt - 1'b1;
          r_state <= (r_cnt == CNT_W'(1)) ? S_IDLE : S_DHI;
        end
        default: r_state <= S_IDLE;
      endcase
      // Stalled mid-packet: drop the partial word and resync on a header.
      if (w_expire) begin
        r_err   <= 1'b1;
        r_state <= S_IDLE;
      end
    end
  end

  assign in_ready = (r_state != S_WR);
  assign busy     = (r_state != S_IDLE);
  assign lut_we   = (r_state == S_WR);
  assign lut_wa   = r_addr;
  assign lut_wd   = r_word;
  assign done     = lut_we & (r_cnt == CNT_W'(1));
  assign err      = r_err;
  assign lut_ra   = dds_ra;
  assign lut_re   = dds_re_req & ~(HOLD_ON_LOAD & busy);

endmodule

// File: tb/tb_lut_load_ctrl.sv
// Scoreboard bench for lut_load_ctrl: expected writes queued as bytes are sent.
// A second instance with reads passing through checks the read gate option.
module tb_lut_load_ctrl;

  localparam int TO = 1023;

  typedef struct {
    logic [6:0]  wa;
    logic [11:0] wd;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        dds_re_req = 1'b0;
  logic [6:0]  dds_ra = '0;

  logic        rdy0, we0, re0, busy0, done0, err0;
  logic [6:0]  wa0, ra0;
  logic [11:0] wd0;
  logic        rdy1, we1, re1, busy1, done1, err1;
  logic [6:0]  wa1, ra1;
  logic [11:0] wd1;

  int   total = 0;
  int   bad = 0;
  int   err_seen = 0;
  exp_t sbq[$];
  exp_t mon_e;
  logic [11:0] wl[$];

  always #5 clk = ~clk;

  lut_load_ctrl #(.WW(12), .DEPTH(128), .TIMEOUT(TO), .HOLD_ON_LOAD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .lut_we(we0), .lut_wa(wa0), .lut_wd(wd0),
    .dds_re_req(dds_re_req), .dds_ra(dds_ra), .lut_re(re0), .lut_ra(ra0),
    .busy(busy0), .done(done0), .err(err0)
  );

  lut_load_ctrl #(.WW(12), .DEPTH(128), .TIMEOUT(TO), .HOLD_ON_LOAD(1'b0)) dut_pt (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .lut_we(we1), .lut_wa(wa1), .lut_wd(wd1),
    .dds_re_req(dds_re_req), .dds_ra(dds_ra), .lut_re(re1), .lut_ra(ra1),
    .busy(busy1), .done(done1), .err(err1)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if ((done0 & ~we0) | (done0 & err0)) begin
        bad++;
        $display("FAIL done_qual: done=%b we=%b err=%b want done only with we and never with err",
                 done0, we0, err0);
      end
      if (err0) err_seen++;
      if (we0) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got wa=%0d wd=%h want no write", wa0, wd0);
        end else begin
          mon_e = sbq.pop_front();
          if ({wa0, wd0, done0} !== {mon_e.wa, mon_e.wd, mon_e.last}) begin
            bad++;
            $display("FAIL write: got wa=%0d wd=%h done=%b want wa=%0d wd=%h done=%b",
                     wa0, wd0, done0, mon_e.wa, mon_e.wd, mon_e.last);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!rdy0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!rdy0) begin
      total++;
      bad++;
      $display("FAIL in_ready_stall: got 0 want 1 within 10 cycles");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [6:0] sa);
    logic [6:0] a;
    logic [7:0] hb;
    int n;
    n = wl.size();
    a = sa;
    send_byte({1'b1, sa});
    send_byte(8'(n - 1));
    for (int i = 0; i < n; i++) begin
      sbq.push_back('{wa: a, wd: wl[i], last: (i == n - 1)});
      a = (a == 7'd127) ? 7'd0 : a + 7'd1;
      hb = {4'($urandom_range(0, 15)), wl[i][11:8]};
      send_byte(hb);
      send_byte(wl[i][7:0]);
    end
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 12 && sbq.size() != 0; i++) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: got %0d pending writes want 0", nm, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({rdy0, we0, wa0, wd0, re0, busy0, done0, err0} !== {1'b1, 1'b0, 7'd0, 12'd0, 4'd0}) begin
      bad++;
      $display("FAIL reset_vals: got rdy=%b we=%b wa=%0d wd=%h re=%b busy=%b done=%b err=%b want rdy=1 rest 0",
               rdy0, we0, wa0, wd0, re0, busy0, done0, err0);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    wl = '{12'hABC, 12'h123, 12'hFFF};
    send_packet(7'd5);
    @(negedge clk);
    total++;
    if ({rdy0, busy0, we0} !== 3'b010 + 3'b001) begin
      bad++;
      $display("FAIL basic_wr_cycle: got rdy=%b busy=%b we=%b want 0 1 1", rdy0, busy0, we0);
    end
    @(negedge clk);
    total++;
    if (busy0 !== 1'b0) begin
      bad++;
      $display("FAIL basic_busy_after: got %b want 0", busy0);
    end
    drain("basic");
  endtask

  task automatic test_wrap();
    int e0;
    e0 = err_seen;
    wl = '{12'h001, 12'h802, 12'h7F3, 12'h444};
    send_packet(7'd126);
    drain("wrap");
    total++;
    if (err_seen != e0) begin
      bad++;
      $display("FAIL wrap_err: got %0d err pulses want 0", err_seen - e0);
    end
  endtask

  task automatic test_long_wrap();
    wl.delete();
    for (int i = 0; i < 130; i++) wl.push_back(12'($urandom));
    send_packet(7'd0);
    drain("long_wrap");
  endtask

  task automatic test_bad_hdr();
    send_byte(8'h05);
    @(negedge clk);
    total++;
    if ({err0, busy0, we0} !== 3'b100) begin
      bad++;
      $display("FAIL badhdr_err: got err=%b busy=%b we=%b want 1 0 0", err0, busy0, we0);
    end
    @(negedge clk);
    total++;
    if (err0 !== 1'b0) begin
      bad++;
      $display("FAIL badhdr_pulse: got err=%b want 0", err0);
    end
    wl = '{12'h9C3};
    send_packet(7'd16);
    drain("badhdr_next");
  endtask

  task automatic test_timeout();
    int n;
    send_byte(8'h80);
    send_byte(8'h00);
    send_byte(8'h0F);
    n = 0;
    while (!err0 && n < TO + 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != TO + 1) begin
      bad++;
      $display("FAIL timeout_latency: got %0d cycles want %0d", n, TO + 1);
    end
    @(negedge clk);
    total++;
    if ({err0, busy0} !== 2'b00) begin
      bad++;
      $display("FAIL timeout_after: got err=%b busy=%b want 0 0", err0, busy0);
    end
    wl = '{12'h5A5};
    send_packet(7'd3);
    drain("timeout_next");
  endtask

  task automatic test_read_gate();
    dds_re_req = 1'b1;
    dds_ra = 7'h33;
    @(negedge clk);
    total++;
    if ({re0, re1, ra0} !== {2'b11, 7'h33}) begin
      bad++;
      $display("FAIL gate_idle: got re0=%b re1=%b ra=%h want 1 1 33", re0, re1, ra0);
    end
    sbq.push_back('{wa: 7'h20, wd: 12'h111, last: 1'b1});
    send_byte(8'hA0);
    @(negedge clk);
    dds_ra = 7'h4C;
    #1;
    total++;
    if ({re0, re1, ra0, ra1} !== {2'b01, 7'h4C, 7'h4C}) begin
      bad++;
      $display("FAIL gate_busy: got re0=%b re1=%b ra0=%h ra1=%h want 0 1 4c 4c",
               re0, re1, ra0, ra1);
    end
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h11);
    drain("gate");
    @(negedge clk);
    total++;
    if (re0 !== 1'b1) begin
      bad++;
      $display("FAIL gate_release: got re0=%b want 1", re0);
    end
    dds_re_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    send_byte(8'h8A);
    send_byte(8'h00);
    send_byte(8'h07);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({rdy0, we0, wa0, wd0, busy0, done0, err0} !== {1'b1, 1'b0, 7'd0, 12'd0, 3'd0}) begin
        bad++;
        $display("FAIL rst_mid: got rdy=%b we=%b wa=%0d wd=%h busy=%b done=%b err=%b want rdy=1 rest 0",
                 rdy0, we0, wa0, wd0, busy0, done0, err0);
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({rdy0, busy0, we0} !== 3'b100) begin
      bad++;
      $display("FAIL rst_release: got rdy=%b busy=%b we=%b want 1 0 0", rdy0, busy0, we0);
    end
    wl = '{12'h777, 12'h0E1};
    send_packet(7'd10);
    drain("rst_next");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_bad_hdr();
    test_timeout();
    test_read_gate();
    test_long_wrap();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
